// File: rtl/vga_frame_fetch.sv
// VGA 640x480@60 timing generator and image-window fetcher.
// Reads the picture window from image RAM and re-times each pixel onto x/y and the syncs.
module vga_frame_fetch #(
  parameter int WIN_X0       = 120,
  parameter int WIN_Y0       = 40,
  parameter int WIN_W        = 400,
  parameter int WIN_H        = 400,
  parameter int ADDR_W       = 18,
  // Line and frame geometry; the defaults are standard 640x480@60.
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic [23:0]       pixel_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_done
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] WX_LO  = 10'(WIN_X0);
  localparam logic [9:0] WX_HI  = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0] WY_LO  = 10'(WIN_Y0);
  localparam logic [9:0] WY_HI  = 10'(WIN_Y0 + WIN_H);
  localparam logic [9:0] LAST_X = 10'(WIN_X0 + WIN_W - 1);
  localparam logic [9:0] LAST_Y = 10'(WIN_Y0 + WIN_H - 1);
  localparam logic [9:0] HS_LO  = 10'(H_SYNC_START);
  localparam logic [9:0] HS_HI  = 10'(H_SYNC_END);
  localparam logic [9:0] VS_LO  = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI  = 10'(V_SYNC_END);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

  logic [9:0]        hc, vc;
  logic              armed;
  logic [ADDR_W-1:0] ac;

  // First pipeline stage: counter-derived values waiting for their RAM data.
  logic [9:0]        h_d, v_d;
  logic              hs_d, vs_d, bl_d, fetch_d;
  logic              done_pend;

  logic              frame_start, armed_now, in_win, fetch;
  logic              hs_now, vs_now, bl_now;
  logic [ADDR_W-1:0] ac_base;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    frame_start = pix_en && (hc == '0) && (vc == '0);
    // The boundary tick already uses the newly sampled start and a cleared address.
    armed_now   = frame_start ? start : armed;
    ac_base     = frame_start ? '0 : ac;
    in_win      = (hc >= WX_LO) && (hc < WX_HI) && (vc >= WY_LO) && (vc < WY_HI);
    fetch       = in_win && armed_now;
    hs_now      = !((hc >= HS_LO) && (hc < HS_HI));
    vs_now      = !((vc >= VS_LO) && (vc < VS_HI));
    bl_now      = (hc < H_VIS) && (vc < V_VIS);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only; each register samples the others' pre-edge values.
    done_pend  <= 1'b0;
    frame_done <= done_pend;
    if (!reset_n) begin
      hc         <= '0;
      vc         <= '0;
      ac         <= '0;
      armed      <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      h_d        <= '0;
      v_d        <= '0;
      hs_d       <= 1'b1;
      vs_d       <= 1'b1;
      bl_d       <= 1'b0;
      fetch_d    <= 1'b0;
      x          <= '0;
      y          <= '0;
      pixel_data <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      blank_n    <= 1'b0;
      frame_done <= 1'b0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end

      armed <= armed_now;
      rd_en <= fetch;
      if (fetch) begin
        rd_addr <= ac_base;
        ac      <= ac_base + 1'b1;
      end else begin
        ac      <= ac_base;
      end

      h_d     <= hc;
      v_d     <= vc;
      hs_d    <= hs_now;
      vs_d    <= vs_now;
      bl_d    <= bl_now;
      fetch_d <= fetch;

      // rd_data for the read issued last tick has been valid for one clk by now.
      x          <= h_d;
      y          <= v_d;
      hsync      <= hs_d;
      vsync      <= vs_d;
      blank_n    <= bl_d;
      pixel_data <= fetch_d ? rd_data : '0;
      done_pend  <= fetch_d && (h_d == LAST_X) && (v_d == LAST_Y);
    end
  end

endmodule
